// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one half-round per clock, ROUNDS+1 cycles from accept to o_valid.
// o_valid/o_keystream/o_last hold until o_ready; new requests are only taken in IDLE.
module chacha_block_core #(
    parameter int ROUNDS    = 20,
    parameter int COUNTER_W = 32
) (
    input  logic                   aclk,
    input  logic                   srst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [255:0]           i_key,
    input  logic [127-COUNTER_W:0] i_nonce,
    input  logic [COUNTER_W-1:0]   i_counter,
    input  logic [7:0]             i_nblocks,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [511:0]           o_keystream,
    output logic                   o_last
);
    localparam int RW = $clog2(ROUNDS);
    localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);
    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    generate
        if (ROUNDS < 2 || ROUNDS > 20 || (ROUNDS % 2) != 0) begin : g_bad_rounds
            $error("chacha_block_core: ROUNDS must be even and within 2..20");
        end
        if (COUNTER_W != 32 && COUNTER_W != 64) begin : g_bad_counter_w
            $error("chacha_block_core: COUNTER_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_OUT} state_t;
    typedef logic [15:0][31:0] blk_t;

    state_t        state_q, state_d;
    blk_t          x_q, x_d, init_q, init_d;
    blk_t          load_st, hr_col, hr_diag, sum, init_inc;
    logic [RW-1:0] r_q, r_d;
    logic [7:0]    rem_q, rem_d;
    logic [63:0]   ctr_inc;
    logic          accept;

    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    // Words 12..15 are {nonce, counter}; a 64-bit counter spills into word 13.
    assign load_st = {i_nonce, i_counter, i_key, SIGMA};

    always_comb begin
        hr_col  = x_q;
        hr_diag = x_q;
        {hr_col[12], hr_col[8],  hr_col[4], hr_col[0]}   = qr(x_q[0], x_q[4], x_q[8],  x_q[12]);
        {hr_col[13], hr_col[9],  hr_col[5], hr_col[1]}   = qr(x_q[1], x_q[5], x_q[9],  x_q[13]);
        {hr_col[14], hr_col[10], hr_col[6], hr_col[2]}   = qr(x_q[2], x_q[6], x_q[10], x_q[14]);
        {hr_col[15], hr_col[11], hr_col[7], hr_col[3]}   = qr(x_q[3], x_q[7], x_q[11], x_q[15]);
        {hr_diag[15], hr_diag[10], hr_diag[5], hr_diag[0]} = qr(x_q[0], x_q[5], x_q[10], x_q[15]);
        {hr_diag[12], hr_diag[11], hr_diag[6], hr_diag[1]} = qr(x_q[1], x_q[6], x_q[11], x_q[12]);
        {hr_diag[13], hr_diag[8],  hr_diag[7], hr_diag[2]} = qr(x_q[2], x_q[7], x_q[8],  x_q[13]);
        {hr_diag[14], hr_diag[9],  hr_diag[4], hr_diag[3]} = qr(x_q[3], x_q[4], x_q[9],  x_q[14]);
    end

    always_comb begin
        sum = '0;
        for (int w = 0; w < 16; w++) begin
            sum[w] = x_q[w] + init_q[w];
        end
        if (COUNTER_W == 64) begin
            ctr_inc = {init_q[13], init_q[12]} + 64'd1;
        end else begin
            ctr_inc = {init_q[13], init_q[12] + 32'd1};
        end
        init_inc     = init_q;
        init_inc[12] = ctr_inc[31:0];
        init_inc[13] = ctr_inc[63:32];
    end

    assign i_ready     = (state_q == S_IDLE) && !srst;
    assign accept      = i_valid && i_ready;
    assign o_valid     = (state_q == S_OUT);
    assign o_keystream = o_valid ? x_q : '0;
    assign o_last      = o_valid && (rem_q == 8'd0);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        init_d  = init_q;
        r_d     = r_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    x_d     = load_st;
                    init_d  = load_st;
                    r_d     = '0;
                    rem_d   = i_nblocks;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                x_d = r_q[0] ? hr_diag : hr_col;
                if (r_q == R_LAST) begin
                    r_d     = '0;
                    state_d = S_ADD;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_ADD: begin
                x_d     = sum;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (o_ready) begin
                    if (rem_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = rem_q - 8'd1;
                        init_d  = init_inc;
                        x_d     = init_inc;
                        r_d     = '0;
                        state_d = S_ROUND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            init_q  <= '0;
            r_q     <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            init_q  <= init_d;
            r_q     <= r_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: tb/tb_chacha_block_core.sv
// Directed and table-driven checks of chacha_block_core against RFC 8439 vectors and a software ChaCha model.
module tb_chacha_block_core;
    logic         aclk = 1'b0;
    logic         srst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready = 1'b1;
    logic [255:0] i_key = '0;
    logic [95:0]  i_nonce = '0;
    logic [31:0]  i_counter = '0;
    logic [7:0]   i_nblocks = '0;
    logic         i_ready, o_valid, o_last;
    logic [511:0] o_keystream;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    chacha_block_core #(.ROUNDS(20), .COUNTER_W(32)) dut (
        .aclk(aclk), .srst(srst), .i_valid(i_valid), .i_ready(i_ready),
        .i_key(i_key), .i_nonce(i_nonce), .i_counter(i_counter), .i_nblocks(i_nblocks),
        .o_valid(o_valid), .o_ready(o_ready), .o_keystream(o_keystream), .o_last(o_last)
    );

    // Sweep instances: j%3 selects 8/12/20 rounds, j<3 selects 32-bit counter.
    logic         sw_valid = 1'b0;
    logic [255:0] sw_key = '0;
    logic [127:0] sw_nc = '0;
    logic [7:0]   sw_nb = '0;
    logic [5:0]   sw_ir, sw_ov, sw_ol;
    logic [511:0] sw_ks [6];

    generate
        for (genvar j = 0; j < 6; j++) begin : g_sw
            localparam int R  = (j % 3 == 0) ? 8 : ((j % 3 == 1) ? 12 : 20);
            localparam int CW = (j < 3) ? 32 : 64;
            chacha_block_core #(.ROUNDS(R), .COUNTER_W(CW)) u_sw (
                .aclk(aclk), .srst(srst), .i_valid(sw_valid), .i_ready(sw_ir[j]),
                .i_key(sw_key), .i_nonce(sw_nc[127:CW]), .i_counter(sw_nc[CW-1:0]),
                .i_nblocks(sw_nb), .o_valid(sw_ov[j]), .o_ready(1'b1),
                .o_keystream(sw_ks[j]), .o_last(sw_ol[j])
            );
        end
    endgenerate

    function automatic int sw_rounds(input int j);
        return (j % 3 == 0) ? 8 : ((j % 3 == 1) ? 12 : 20);
    endfunction

    function automatic int sw_cw(input int j);
        return (j < 3) ? 32 : 64;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [511:0] model_block(input int rounds, input logic [511:0] st);
        logic [31:0]  x [16];
        logic [511:0] res;
        for (int w = 0; w < 16; w++) x[w] = st[32*w +: 32];
        for (int r = 0; r < rounds; r++) begin
            for (int q = 0; q < 4; q++) begin
                int a, b, c, d;
                a = q;
                if (r % 2 == 0) begin
                    b = q + 4; c = q + 8; d = q + 12;
                end else begin
                    b = 4 + (q + 1) % 4; c = 8 + (q + 2) % 4; d = 12 + (q + 3) % 4;
                end
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
            end
        end
        for (int w = 0; w < 16; w++) res[32*w +: 32] = x[w] + st[32*w +: 32];
        return res;
    endfunction

    // Initial state for block b of a request whose words 12..15 are nc.
    function automatic logic [511:0] mk_state(input logic [255:0] k, input logic [127:0] nc,
                                              input int cw, input int b);
        logic [511:0] s;
        logic [127:0] sig;
        sig = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        s = {nc, k, sig};
        if (cw == 32) s[384 +: 32] = s[384 +: 32] + b[31:0];
        else          s[384 +: 64] = s[384 +: 64] + 64'(b);
        return s;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                        input logic [7:0] nb);
        @(negedge aclk);
        i_key = k; i_nonce = n; i_counter = c; i_nblocks = nb; i_valid = 1'b1;
        chk("req_i_ready", i_ready, 1'b1);
        @(posedge aclk);
        #1 i_valid = 1'b0;
    endtask

    // Counts rising edges until o_valid is seen; capped so a dead DUT cannot hang the run.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge aclk);
            n++;
            @(negedge aclk);
        end while (!o_valid && n < 100);
    endtask

    typedef struct {
        logic [255:0] key;
        logic [95:0]  nonce;
        logic [31:0]  ctr;
        logic [31:0]  w0, w1, w15;
    } vec_t;

    vec_t         vecs [2];
    logic [255:0] rfc_key, k2;
    logic [95:0]  n2;
    logic [511:0] held, exp_blk;
    int           n, bad, cnt [6], cyc, done;

    initial begin
        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        vecs[0] = '{key: rfc_key, nonce: {32'h00000000, 32'h4a000000, 32'h09000000}, ctr: 32'd1,
                    w0: 32'he4e7f110, w1: 32'h15593bd1, w15: 32'h4e3c50a2};
        vecs[1] = '{key: '0, nonce: '0, ctr: 32'd0,
                    w0: 32'hade0b876, w1: 32'h903df1a0, w15: 32'h8665eeb2};

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_i_ready_low", i_ready, 1'b0);
        chk("rst_o_valid", o_valid, 1'b0);
        srst = 1'b0;
        #1;
        chk("rst_i_ready_high", i_ready, 1'b1);
        chk("rst_o_last", o_last, 1'b0);
        chk("rst_keystream", o_keystream, '0);

        for (int v = 0; v < 2; v++) begin
            send(vecs[v].key, vecs[v].nonce, vecs[v].ctr, 8'd0);
            wait_out(n);
            chk($sformatf("vec%0d_latency", v), n, 21);
            chk($sformatf("vec%0d_w0", v), o_keystream[31:0], vecs[v].w0);
            chk($sformatf("vec%0d_w1", v), o_keystream[63:32], vecs[v].w1);
            chk($sformatf("vec%0d_w15", v), o_keystream[511:480], vecs[v].w15);
            chk($sformatf("vec%0d_model", v), o_keystream,
                model_block(20, mk_state(vecs[v].key, {vecs[v].nonce, vecs[v].ctr}, 32, 0)));
            chk($sformatf("vec%0d_last", v), o_last, 1'b1);
            @(posedge aclk);
            @(negedge aclk);
            chk($sformatf("vec%0d_idle_valid", v), o_valid, 1'b0);
            chk($sformatf("vec%0d_idle_ready", v), i_ready, 1'b1);
        end

        // Burst crossing the 32-bit counter wrap.
        k2 = {8{32'h1234abcd}} ^ rfc_key;
        n2 = {32'hcafef00d, 32'h00000007, 32'hdeadbeef};
        send(k2, n2, 32'hfffffffe, 8'd2);
        for (int b = 0; b < 3; b++) begin
            wait_out(n);
            chk($sformatf("burst%0d_spacing", b), n, (b == 0) ? 21 : 22);
            chk($sformatf("burst%0d_block", b), o_keystream,
                model_block(20, mk_state(k2, {n2, 32'hfffffffe}, 32, b)));
            chk($sformatf("burst%0d_last", b), o_last, b == 2);
        end
        @(posedge aclk);
        @(negedge aclk);
        chk("burst_done_valid", o_valid, 1'b0);

        // Backpressure with a competing request presented during OUT.
        o_ready = 1'b0;
        send(~k2, n2 ^ 96'h5, 32'd77, 8'd0);
        wait_out(n);
        chk("bp_latency", n, 21);
        held = o_keystream;
        chk("bp_block", held, model_block(20, mk_state(~k2, {n2 ^ 96'h5, 32'd77}, 32, 0)));
        i_key = k2; i_valid = 1'b1;
        bad = 0;
        repeat (50) begin
            @(posedge aclk);
            @(negedge aclk);
            if (!o_valid || o_keystream !== held || i_ready || !o_last) bad++;
        end
        chk("bp_stable_cycles_bad", bad, 0);
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("bp_release_valid", o_valid, 1'b0);
        chk("bp_release_ready", i_ready, 1'b1);
        bad = 0;
        repeat (30) begin
            @(negedge aclk);
            if (o_valid) bad++;
        end
        chk("bp_no_queued_request", bad, 0);

        // Reset while the working state is at half-round 7.
        send(k2, n2, 32'd5, 8'd3);
        repeat (7) @(posedge aclk);
        @(negedge aclk);
        srst = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_keystream", o_keystream, '0);
        chk("midrst_ready_in_reset", i_ready, 1'b0);
        srst = 1'b0;
        #1;
        chk("midrst_ready_after", i_ready, 1'b1);
        bad = 0;
        repeat (30) begin
            @(negedge aclk);
            if (o_valid) bad++;
        end
        chk("midrst_no_partial", bad, 0);
        send(rfc_key, vecs[0].nonce, 32'd1, 8'd0);
        wait_out(n);
        chk("midrst_fresh_latency", n, 21);
        chk("midrst_fresh_w0", o_keystream[31:0], 32'he4e7f110);

        // Parameter sweep; request 0 straddles the low-word carry of a 64-bit counter.
        for (int t = 0; t < 5; t++) begin
            @(negedge aclk);
            for (int i = 0; i < 8; i++) sw_key[32*i +: 32] = $urandom;
            if (t == 0) begin
                sw_nc = {$urandom, $urandom, 32'h00000000, 32'hffffffff};
                sw_nb = 8'd1;
            end else begin
                sw_nc = {$urandom, $urandom, $urandom, $urandom};
                sw_nb = 8'($urandom_range(0, 2));
            end
            chk($sformatf("sw%0d_ready", t), sw_ir, 6'h3f);
            sw_valid = 1'b1;
            @(posedge aclk);
            #1 sw_valid = 1'b0;
            for (int j = 0; j < 6; j++) cnt[j] = 0;
            cyc = 0;
            done = 0;
            while (done < 6 && cyc < 2000) begin
                @(negedge aclk);
                cyc++;
                done = 0;
                for (int j = 0; j < 6; j++) begin
                    if (sw_ov[j] && cnt[j] <= int'(sw_nb)) begin
                        exp_blk = model_block(sw_rounds(j), mk_state(sw_key, sw_nc, sw_cw(j), cnt[j]));
                        chk($sformatf("sw%0d_r%0d_cw%0d_blk%0d", t, sw_rounds(j), sw_cw(j), cnt[j]),
                            sw_ks[j], exp_blk);
                        chk($sformatf("sw%0d_j%0d_last%0d", t, j, cnt[j]), sw_ol[j], cnt[j] == int'(sw_nb));
                        cnt[j]++;
                    end
                    if (cnt[j] == int'(sw_nb) + 1) done++;
                end
            end
            for (int j = 0; j < 6; j++)
                chk($sformatf("sw%0d_j%0d_block_count", t, j), cnt[j], int'(sw_nb) + 1);
            repeat (2) @(posedge aclk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
